// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared encodings for the multi-cycle CPU controller: FSM state
//             enum, opcode/ext field values, condition codes, flag indices.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_EXEC       = 3'd2,
        S_MEM_WAIT   = 3'd3,
        S_HALT       = 3'd4
    } state_t;

    // Major opcodes (instr[15:12])
    localparam logic [3:0] c_OP_RTYPE = 4'b0000;
    localparam logic [3:0] c_OP_ANDI  = 4'b0010;
    localparam logic [3:0] c_OP_ORI   = 4'b0011;
    localparam logic [3:0] c_OP_MEM   = 4'b0100;
    localparam logic [3:0] c_OP_UNDEF = 4'b1000;
    localparam logic [3:0] c_OP_CMPI  = 4'b1011;
    localparam logic [3:0] c_OP_BCOND = 4'b1100;
    localparam logic [3:0] c_OP_MOVI  = 4'b1101;

    // Extended opcodes (instr[7:4])
    localparam logic [3:0] c_EXT_LOAD  = 4'b0000;
    localparam logic [3:0] c_EXT_HALT  = 4'b0001;
    localparam logic [3:0] c_EXT_STOR  = 4'b0100;
    localparam logic [3:0] c_EXT_JAL   = 4'b1000;
    localparam logic [3:0] c_EXT_CMP   = 4'b1011;
    localparam logic [3:0] c_EXT_JCOND = 4'b1100;

    // Condition codes carried in the Rdest field
    localparam logic [3:0] c_COND_EQ = 4'b0000;
    localparam logic [3:0] c_COND_NE = 4'b0001;
    localparam logic [3:0] c_COND_CS = 4'b0010;
    localparam logic [3:0] c_COND_CC = 4'b0011;
    localparam logic [3:0] c_COND_HI = 4'b0100;
    localparam logic [3:0] c_COND_LS = 4'b0101;
    localparam logic [3:0] c_COND_GT = 4'b0110;
    localparam logic [3:0] c_COND_LE = 4'b0111;
    localparam logic [3:0] c_COND_FS = 4'b1000;
    localparam logic [3:0] c_COND_FC = 4'b1001;
    localparam logic [3:0] c_COND_UC = 4'b1110;

    // Bit positions inside the {L,C,F,Z,N} flags vector
    localparam int c_FLAG_L = 4;
    localparam int c_FLAG_C = 3;
    localparam int c_FLAG_F = 2;
    localparam int c_FLAG_Z = 1;
    localparam int c_FLAG_N = 0;

    // Immediate ALU ops are exactly the opcodes whose low two bits are non-zero
    function automatic logic is_imm_op(input logic [3:0] op);
        return (op[1:0] != 2'b00);
    endfunction

    // Logical immediates and MOVI take an unsigned byte
    function automatic logic is_zext_op(input logic [3:0] op);
        return (op == c_OP_ANDI) || (op == c_OP_ORI) || (op == c_OP_MOVI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : cond_eval
//  Purpose  : Combinational branch-condition evaluator: flags + 4-bit
//             condition code -> taken.
//  Revision : 1.0 - initial release
// ============================================================================
module cond_eval
    import cpu_pkg::*;
(
    input  logic [4:0] i_flags,
    input  logic [3:0] i_cond,
    output logic       o_taken
);

    // Select the flag test named by the condition code; unlisted codes never take
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            c_COND_EQ: o_taken =  i_flags[c_FLAG_Z];
            c_COND_NE: o_taken = ~i_flags[c_FLAG_Z];
            c_COND_CS: o_taken =  i_flags[c_FLAG_C];
            c_COND_CC: o_taken = ~i_flags[c_FLAG_C];
            c_COND_HI: o_taken =  i_flags[c_FLAG_L];
            c_COND_LS: o_taken = ~i_flags[c_FLAG_L];
            c_COND_GT: o_taken =  i_flags[c_FLAG_N];
            c_COND_LE: o_taken = ~i_flags[c_FLAG_N];
            c_COND_FS: o_taken =  i_flags[c_FLAG_F];
            c_COND_FC: o_taken = ~i_flags[c_FLAG_F];
            c_COND_UC: o_taken = 1'b1;
            default:   o_taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_controller
//  Purpose  : Multi-cycle fetch/decode/execute control FSM. Owns the PC and
//             the memory request handshake; drives datapath register and
//             flag enables, operand selects and the immediate.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_controller
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic [15:0] mux_a_out,
    input  logic [15:0] mux_b_out,
    input  logic [4:0]  flags,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] regEnable,
    output logic [3:0]  a_select,
    output logic [3:0]  b_select,
    output logic        use_imm,
    output logic [15:0] immediate,
    output logic [7:0]  opCode,
    output logic        flagsEn,
    output logic        bus_select,
    output logic [15:0] pc,
    output logic        fault
);

    localparam logic [15:0] c_TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_instr;
    logic [15:0] r_pc;
    logic        r_fault;
    logic [15:0] r_tmo;
    logic        r_req;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_reg_en;
    logic [3:0]  r_a_sel;
    logic [3:0]  r_b_sel;
    logic        r_use_imm;
    logic [15:0] r_imm;
    logic [7:0]  r_opcode;
    logic        r_flags_en;
    logic        r_bus_sel;

    // Fields of the latched instruction, used while executing
    logic [3:0]  w_op;
    logic [3:0]  w_ext;
    logic [3:0]  w_rdest;
    logic [15:0] w_disp;
    logic        w_taken;
    logic        w_ld_done;

    // Decode of the word arriving on mem_rdata, so EXEC outputs are registered
    logic [3:0]  w_f_op;
    logic [3:0]  w_f_ext;
    logic [7:0]  w_f_imm8;
    logic        w_f_wb;
    logic        w_f_flg;
    logic        w_f_bus;
    logic        w_f_use_imm;
    logic [15:0] w_f_imm;

    assign w_op     = r_instr[15:12];
    assign w_ext    = r_instr[7:4];
    assign w_rdest  = r_instr[11:8];
    assign w_disp   = {{8{r_instr[7]}}, r_instr[7:0]};

    assign w_f_op   = mem_rdata[15:12];
    assign w_f_ext  = mem_rdata[7:4];
    assign w_f_imm8 = mem_rdata[7:0];

    cond_eval u_cond_eval (
        .i_flags (flags),
        .i_cond  (w_rdest),
        .o_taken (w_taken)
    );

    // Load data is only valid while mem_ready is high, so its write-back pulse
    // is qualified by mem_ready in the same cycle rather than registered.
    assign w_ld_done = ~reset && (r_state == S_MEM_WAIT) && mem_ready && ~r_we;

    // Classify the incoming instruction word into write-back/flag/immediate controls
    always_comb begin
        w_f_wb      = 1'b0;
        w_f_flg     = 1'b0;
        w_f_bus     = 1'b0;
        w_f_use_imm = 1'b0;
        w_f_imm     = 16'h0000;
        if (w_f_op == c_OP_RTYPE) begin
            w_f_flg = 1'b1;
            w_f_wb  = (w_f_ext != c_EXT_CMP);
        end else if (is_imm_op(w_f_op)) begin
            w_f_flg     = 1'b1;
            w_f_wb      = (w_f_op != c_OP_CMPI);
            w_f_use_imm = 1'b1;
            w_f_imm     = is_zext_op(w_f_op) ? {8'h00, w_f_imm8}
                                             : {{8{w_f_imm8[7]}}, w_f_imm8};
        end else if ((w_f_op == c_OP_MEM) && (w_f_ext == c_EXT_JAL)) begin
            w_f_wb  = 1'b1;
            w_f_bus = 1'b1;
        end
    end

    // Controller FSM: state, PC, fault and all registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_instr    <= 16'h0000;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_tmo      <= 16'h0000;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_reg_en   <= 16'h0000;
            r_a_sel    <= 4'h0;
            r_b_sel    <= 4'h0;
            r_use_imm  <= 1'b0;
            r_imm      <= 16'h0000;
            r_opcode   <= 8'h00;
            r_flags_en <= 1'b0;
            r_bus_sel  <= 1'b0;
        end else begin
            // Enables are single-cycle pulses unless re-armed below
            r_reg_en   <= 16'h0000;
            r_flags_en <= 1'b0;
            r_bus_sel  <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_req   <= 1'b1;
                    r_we    <= 1'b0;
                    r_addr  <= r_pc;
                    r_tmo   <= 16'h0000;
                    r_state <= S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (mem_ready) begin
                        r_req      <= 1'b0;
                        r_instr    <= mem_rdata;
                        r_pc       <= r_pc + 16'd1;
                        r_a_sel    <= mem_rdata[11:8];
                        r_b_sel    <= mem_rdata[3:0];
                        r_opcode   <= {w_f_op, w_f_ext};
                        r_use_imm  <= w_f_use_imm;
                        r_imm      <= w_f_imm;
                        r_reg_en   <= w_f_wb ? (16'd1 << mem_rdata[11:8]) : 16'h0000;
                        r_flags_en <= w_f_flg;
                        r_bus_sel  <= w_f_bus;
                        r_state    <= S_EXEC;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (w_op)
                        c_OP_MEM: begin
                            case (w_ext)
                                c_EXT_LOAD: begin
                                    r_req   <= 1'b1;
                                    r_we    <= 1'b0;
                                    r_addr  <= mux_b_out;
                                    r_tmo   <= 16'h0000;
                                    r_state <= S_MEM_WAIT;
                                end
                                c_EXT_STOR: begin
                                    r_req   <= 1'b1;
                                    r_we    <= 1'b1;
                                    r_addr  <= mux_b_out;
                                    r_wdata <= mux_a_out;
                                    r_tmo   <= 16'h0000;
                                    r_state <= S_MEM_WAIT;
                                end
                                c_EXT_JAL:   r_pc <= mux_b_out;
                                c_EXT_JCOND: if (w_taken) r_pc <= mux_b_out;
                                c_EXT_HALT:  r_state <= S_HALT;
                                default:     r_fault <= 1'b1;
                            endcase
                        end
                        // r_pc already points past the branch here
                        c_OP_BCOND: if (w_taken) r_pc <= r_pc + w_disp;
                        c_OP_UNDEF: r_fault <= 1'b1;
                        default: ;
                    endcase
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= S_FETCH;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_HALT: begin
                    r_req <= 1'b0;
                    r_we  <= 1'b0;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Write strobes are suppressed while reset is high so an abandoned
    // instruction never commits in the reset cycle.
    assign regEnable  = reset ? 16'h0000
                              : (r_reg_en | (w_ld_done ? (16'd1 << w_rdest) : 16'h0000));
    assign flagsEn    = r_flags_en & ~reset;
    assign bus_select = ~reset & (r_bus_sel | w_ld_done);

    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign a_select   = r_a_sel;
    assign b_select   = r_b_sel;
    assign use_imm    = r_use_imm;
    assign immediate  = r_imm;
    assign opCode     = r_opcode;
    assign pc         = r_pc;
    assign fault      = r_fault;

endmodule
`default_nettype wire
